button_conditioner: RTL and testbench

Multi-channel, parametrised button conditioner for the game's push-button inputs (direction keys, start/pause). Each channel synchronises its raw input, debounces it symmetrically on both edges, and produces a clean level plus one-cycle press, release and auto-repeat pulses. It sits between the board pins and the game controller FSM, so the controller never polls raw or bouncing signals.

---
 rtl/button_conditioner.sv | 181 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, symmetric debounce FSM and
// auto-repeat generator for the game's push buttons. Produces a clean level
// plus one-cycle press, release and repeat pulses for the controller FSM.
// The release and repeat outputs are named release_pulse and repeat_pulse
// because "release" and "repeat" are reserved words in SystemVerilog.
module button_conditioner #(
  parameter int N_CH            = 5,
  parameter int CNT_W           = 24,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_press
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  // Terminal counts; a one-cycle debounce skips the pending states entirely.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               DB_ONE  = (DEBOUNCE_CYCLES == 1);

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] press_fire;

  // Two-flop synchroniser bringing the raw pins into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  // Registered OR of the press events so it lines up with the press pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_fire;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] rcnt;
    logic             phase;
    logic             level_r;
    logic             press_r;
    logic             release_r;
    logic             repeat_r;

    // A press is accepted on the edge that completes the debounce window.
    assign press_fire[i] = s2[i] &&
                           (((state == RELEASED) && DB_ONE) ||
                            ((state == PRESS_PEND) && (dcnt == DB_LAST)));

    assign level[i]         = level_r;
    assign press[i]         = press_r;
    assign release_pulse[i] = release_r;
    assign repeat_pulse[i]  = repeat_r;

    // Debounce FSM with auto-repeat; phase 0 waits REPEAT_DELAY, phase 1 REPEAT_PERIOD.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= RELEASED;
        dcnt      <= '0;
        rcnt      <= '0;
        phase     <= 1'b0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
      end else begin
        press_r   <= press_fire[i];
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
        case (state)
          RELEASED: begin
            if (s2[i]) begin
              if (DB_ONE) begin
                state   <= PRESSED;
                level_r <= 1'b1;
                dcnt    <= '0;
                rcnt    <= '0;
                phase   <= 1'b0;
              end else begin
                state <= PRESS_PEND;
                dcnt  <= CNT_ONE;
              end
            end else begin
              dcnt <= '0;
            end
          end
          PRESS_PEND: begin
            if (!s2[i]) begin
              state <= RELEASED;
              dcnt  <= '0;
            end else if (dcnt == DB_LAST) begin
              state   <= PRESSED;
              level_r <= 1'b1;
              dcnt    <= '0;
              rcnt    <= '0;
              phase   <= 1'b0;
            end else begin
              dcnt <= dcnt + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!s2[i]) begin
              if (DB_ONE) begin
                state     <= RELEASED;
                level_r   <= 1'b0;
                release_r <= 1'b1;
                dcnt      <= '0;
                rcnt      <= '0;
                phase     <= 1'b0;
              end else begin
                state <= RELEASE_PEND;
                dcnt  <= CNT_ONE;
              end
            end else if (repeat_en[i]) begin
              if ((!phase && (rcnt == RD_LAST)) || (phase && (rcnt == RP_LAST))) begin
                repeat_r <= 1'b1;
                rcnt     <= '0;
                phase    <= 1'b1;
              end else begin
                rcnt <= rcnt + CNT_ONE;
              end
            end else begin
              rcnt  <= '0;
              phase <= 1'b0;
            end
          end
          RELEASE_PEND: begin
            if (s2[i]) begin
              state <= PRESSED;
              dcnt  <= '0;
            end else if (dcnt == DB_LAST) begin
              state     <= RELEASED;
              level_r   <= 1'b0;
              release_r <= 1'b1;
              dcnt      <= '0;
              rcnt      <= '0;
              phase     <= 1'b0;
            end else begin
              dcnt <= dcnt + CNT_ONE;
            end
          end
          default: begin
            state   <= RELEASED;
            level_r <= 1'b0;
            dcnt    <= '0;
            rcnt    <= '0;
            phase   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with a short debounce window
// (4 cycles), repeat delay 10 and repeat period 3 on two channels.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] button;
  logic [1:0] repeat_en;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] release_pulse;
  logic [1:0] repeat_pulse;
  logic       any_press;

  int pass_cnt;
  int total_cnt;

  button_conditioner #(
    .N_CH(2),
    .CNT_W(8),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .repeat_en(repeat_en),
    .level(level),
    .press(press),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse),
    .any_press(any_press)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive both input vectors at once.
  task automatic applyStimulus(input logic [1:0] btn, input logic [1:0] en);
    button    = btn;
    repeat_en = en;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) begin
      pass_cnt++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n cycles, always landing on a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed sequence; outputs are sampled on falling edges.
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    applyStimulus(2'b00, 2'b00);
    tick(2);
    checkOutput("reset_state", {level, press, release_pulse, repeat_pulse, any_press}, 32'h0);
    rst = 1'b0;
    tick(2);

    // Clean press on channel 0.
    applyStimulus(2'b01, 2'b00);
    tick(5);
    checkOutput("press_not_early", {level, press}, 32'h0);
    tick(1);
    checkOutput("press_level", level, 32'h1);
    checkOutput("press_pulse", press, 32'h1);
    checkOutput("press_any", any_press, 32'h1);
    tick(1);
    checkOutput("press_one_cycle", {press, any_press}, 32'h0);
    checkOutput("press_level_held", level, 32'h1);

    // Clean release on channel 0.
    applyStimulus(2'b00, 2'b00);
    tick(5);
    checkOutput("release_not_early", {level, release_pulse}, 32'h4);
    tick(1);
    checkOutput("release_level", level, 32'h0);
    checkOutput("release_pulse", release_pulse, 32'h1);
    tick(1);
    checkOutput("release_one_cycle", release_pulse, 32'h0);

    // Bounce: three high cycles then one low, five times.
    for (int r = 0; r < 5; r++) begin
      applyStimulus(2'b01, 2'b00);
      tick(3);
      applyStimulus(2'b00, 2'b00);
      tick(1);
      checkOutput("bounce_reject", {level, press}, 32'h0);
    end
    tick(4);
    checkOutput("bounce_settled", {level, press}, 32'h0);
    applyStimulus(2'b01, 2'b00);
    tick(5);
    checkOutput("hold_not_early", level, 32'h0);
    tick(1);
    checkOutput("hold_press", {level, press}, 32'h5);
    tick(1);

    // Three-cycle low glitch while pressed must not release.
    applyStimulus(2'b00, 2'b00);
    tick(3);
    applyStimulus(2'b01, 2'b00);
    for (int j = 0; j < 8; j++) begin
      tick(1);
      checkOutput("glitch_hold", {level, release_pulse, repeat_pulse}, 32'h10);
    end

    // Enabling repeat while held starts the full delay from the enable edge.
    applyStimulus(2'b01, 2'b01);
    for (int j = 1; j <= 40; j++) begin
      tick(1);
      checkOutput("repeat_enabled", repeat_pulse,
                  (j >= 10 && ((j - 10) % 3) == 0) ? 32'h1 : 32'h0);
    end
    applyStimulus(2'b01, 2'b00);
    for (int j = 0; j < 12; j++) begin
      tick(1);
      checkOutput("repeat_disabled", repeat_pulse, 32'h0);
    end
    applyStimulus(2'b00, 2'b01);
    for (int j = 0; j < 12; j++) begin
      tick(1);
      checkOutput("repeat_after_release", repeat_pulse, 32'h0);
    end
    checkOutput("released_before_simul", level, 32'h0);

    // Both channels pressed together, repeat enabled on both.
    applyStimulus(2'b11, 2'b11);
    tick(5);
    checkOutput("simul_not_early", press, 32'h0);
    tick(1);
    checkOutput("simul_press", press, 32'h3);
    checkOutput("simul_any", any_press, 32'h1);
    checkOutput("simul_no_repeat_on_press", repeat_pulse, 32'h0);
    tick(1);
    checkOutput("simul_any_one_cycle", {press, any_press}, 32'h0);
    for (int j = 8; j <= 24; j++) begin
      tick(1);
      checkOutput("simul_repeat", repeat_pulse,
                  (j >= 16 && ((j - 16) % 3) == 0) ? 32'h3 : 32'h0);
    end
    applyStimulus(2'b00, 2'b00);
    tick(12);
    checkOutput("simul_released", level, 32'h0);

    // Reset in the middle of a debounce window.
    applyStimulus(2'b01, 2'b00);
    tick(4);
    rst = 1'b1;
    #1;
    checkOutput("reset_mid_debounce", {level, press, release_pulse, repeat_pulse, any_press}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(5);
    checkOutput("post_reset1_not_early", level, 32'h0);
    tick(1);
    checkOutput("post_reset1_press", {level, press}, 32'h5);

    // Reset while held.
    tick(3);
    rst = 1'b1;
    #1;
    checkOutput("reset_mid_hold", {level, press, release_pulse, repeat_pulse, any_press}, 32'h0);
    tick(1);
    rst = 1'b0;
    tick(5);
    checkOutput("post_reset2_not_early", level, 32'h0);
    tick(1);
    checkOutput("post_reset2_press", {level, press}, 32'h5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
